// File: rtl/adder_sequencer.sv
// Byte-serial multi-limb adder sequencer: drives an external 8-bit adder one limb
// per cycle, rippling the carry through a register, with valid/ready on both sides.
module adder_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic                  cin,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_result;
    logic [IDXW-1:0] r_idx;
    logic            r_carry;
    logic            r_cout;
    logic            r_ovf;
    logic            w_accept;
    logic            w_last_limb;
    logic            w_ovf_nxt;

    assign w_accept    = (r_state == IDLE) && start_valid;
    assign w_last_limb = (r_state == RUN) && (r_idx == LAST_IDX);
    // Signed overflow: operands share a sign that the top limb's sum bit does not.
    assign w_ovf_nxt   = (r_a[W-1] == r_b[W-1]) && (add_sum[7] != r_a[W-1]);

    // NOTE: every signal driven here gets a default first so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (start_valid)  w_state_nxt = RUN;
            RUN:  if (w_last_limb)  w_state_nxt = DONE;
            DONE: if (res_ready)    w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (r_state == RUN) begin
            add_a   = r_a[8*r_idx +: 8];
            add_b   = r_b[8*r_idx +: 8];
            add_cin = r_carry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_carry <= cin;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_result[8*r_idx +: 8] <= add_sum;
            r_carry                <= add_cout;
            r_idx                  <= r_idx + IDXW'(1);
            if (w_last_limb) begin
                r_cout <= add_cout;
                r_ovf  <= w_ovf_nxt;
            end
        end
    end

    assign start_ready = (r_state == IDLE);
    assign res_valid   = (r_state == DONE);
    assign result      = r_result;
    assign cout        = r_cout;
    assign ovf         = r_ovf;

endmodule
